// File: rtl/mic_pkg.sv
// mic_pkg: definitions shared between MIC initiators and responders.
//   - Bit positions of the request/response header fields
//   - Encodings of the size field inside byte_enables
//   - Responder FSM state encoding
//   - be_strobe(): turns byte_enables into an 8-lane write strobe
package mic_pkg;

    localparam int HDR_RNW     = 63;
    localparam int HDR_BE_HI   = 62;
    localparam int HDR_BE_LO   = 58;
    localparam int HDR_LEN_HI  = 57;
    localparam int HDR_LEN_LO  = 50;
    localparam int HDR_SRC_HI  = 49;
    localparam int HDR_SRC_LO  = 42;
    localparam int HDR_RESP    = 41;
    localparam int HDR_ADDR_HI = 28;
    localparam int HDR_ADDR_LO = 0;

    // Size field, byte_enables[4:3]
    localparam logic [1:0] SZ_8  = 2'b00;
    localparam logic [1:0] SZ_16 = 2'b01;
    localparam logic [1:0] SZ_32 = 2'b10;
    localparam logic [1:0] SZ_64 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_WR_ACK  = 3'd3,
        ST_RD_HDR  = 3'd4,
        ST_RD_DATA = 3'd5
    } mic_state_e;

    // Lane strobe for a single-beat access: size selects the lane count,
    // byte_enables[2:0] is the starting lane.
    function automatic logic [7:0] be_strobe(input logic [4:0] be);
        logic [7:0] strb;
        case (be[4:3])
            SZ_64:   strb = 8'hFF;
            SZ_32:   strb = 8'h0F << be[2:0];
            SZ_16:   strb = 8'h03 << be[2:0];
            SZ_8:    strb = 8'h01 << be[2:0];
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mic_skid2.sv
// mic_skid2: 2-entry valid/ready buffer with registered outputs.
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_data     push side (caller only pushes when space exists)
//   out_valid, out_ready  pop side handshake
//   out_data              head entry
//   count                 current occupancy (0..2)
module mic_skid2 #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [1:0]   cnt_r, cnt_s;
    logic [W-1:0] e0_r, e0_s, e1_r, e1_s;
    logic         valid_r;
    logic         pop_s;

    assign pop_s = valid_r & out_ready;

    // Next occupancy and entry contents; e0 is always the head
    always_comb begin
        cnt_s = cnt_r;
        e0_s  = e0_r;
        e1_s  = e1_r;
        case (cnt_r)
            2'd0: begin
                if (in_valid) begin
                    e0_s  = in_data;
                    cnt_s = 2'd1;
                end else begin
                    cnt_s = 2'd0;
                end
            end
            2'd1: begin
                if (in_valid && pop_s) begin
                    e0_s = in_data;
                end else if (in_valid) begin
                    e1_s  = in_data;
                    cnt_s = 2'd2;
                end else if (pop_s) begin
                    cnt_s = 2'd0;
                end else begin
                    cnt_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    e0_s = e1_r;
                    if (in_valid) begin
                        e1_s = in_data;
                    end else begin
                        cnt_s = 2'd1;
                    end
                end else begin
                    cnt_s = 2'd2;
                end
            end
            default: cnt_s = 2'd0;
        endcase
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 2'd0;
            e0_r    <= '0;
            e1_r    <= '0;
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            e0_r    <= e0_s;
            e1_r    <= e1_s;
            valid_r <= (cnt_s != 2'd0);
        end
    end

    assign out_valid = valid_r;
    assign out_data  = e0_r;
    assign count     = cnt_r;

endmodule

// File: rtl/mic_s_bram.sv
// mic_s_bram: MIC responder in front of a 64-bit-wide on-chip RAM.
//   clk, reset              clock, async active-low reset
//   I_TVALID/TREADY/TDATA/TLAST  request stream (header then write data)
//   O_TVALID/TREADY/TDATA/TLAST  response stream (header then read data)
//   err_pulse               one-cycle pulse on a malformed packet
//   busy                    high whenever the FSM is not idle
// Every response beat (write ack, read header, read data) goes through the
// 2-entry skid buffer, so all O_ outputs come straight from registers.
module mic_s_bram
    import mic_pkg::*;
#(
    parameter int MEM_DEPTH_L2 = 9,
    parameter     NAME         = "MIC_BRAM"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        I_TVALID,
    output logic        I_TREADY,
    input  logic [63:0] I_TDATA,
    input  logic        I_TLAST,
    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic [63:0] O_TDATA,
    output logic        O_TLAST,
    output logic        err_pulse,
    output logic        busy
);

    localparam int AW    = MEM_DEPTH_L2;
    localparam int DEPTH = 1 << AW;

    mic_state_e        state_r, state_s;
    logic [63:0]       hdr_r;
    logic              drain_to_rd_r, drain_rd_s;
    logic [7:0]        beat_cnt_r;
    logic [8:0]        iss_cnt_r;
    logic              pend_r, pend_last_r;
    logic [63:0]       ram_q_r;
    logic              ready_r, busy_r, err_r;
    logic [63:0]       mem_r [DEPTH];

    logic              in_fire_s, pop_s, err_s, wr_en_s, cnt_inc_s, accept_s;
    logic              hdr_push_s, hdr_last_s, rd_start_s, rd_issue_s, rd_last_s;
    logic [63:0]       hdr_src_s, resp_hdr_s;
    logic [7:0]        len_s, wr_strb_s;
    logic [AW-1:0]     base_s, wr_word_s, rd_word_s;
    logic [2:0]        occ_s;
    logic [1:0]        skid_cnt_s;
    logic              skid_push_s;
    logic [64:0]       skid_in_s, skid_out_s;

    assign in_fire_s = I_TVALID & ready_r;
    assign pop_s     = O_TVALID & O_TREADY;

    // The header is still on I_TDATA in IDLE; afterwards it is held in hdr_r
    assign hdr_src_s  = (state_r == ST_IDLE) ? I_TDATA : hdr_r;
    assign resp_hdr_s = hdr_src_s | (64'd1 << HDR_RESP);
    assign len_s      = hdr_src_s[HDR_LEN_HI:HDR_LEN_LO];
    assign base_s     = hdr_src_s[HDR_ADDR_LO +: AW];
    assign wr_word_s  = base_s + AW'(beat_cnt_r);
    assign rd_word_s  = base_s + AW'(iss_cnt_r[7:0]);
    assign wr_strb_s  = (len_s == 8'd0) ? be_strobe(hdr_src_s[HDR_BE_HI:HDR_BE_LO]) : 8'hFF;
    assign rd_last_s  = (iss_cnt_r == {1'b0, len_s});

    // Occupancy the skid buffer will have after this edge, counting the RAM
    // word already in flight; a new read is issued only if that leaves room.
    assign occ_s = {1'b0, skid_cnt_s} + {2'b00, skid_push_s} - {2'b00, pop_s};

    // Reads start in the header-accept cycle so data trails the header
    // without a bubble.
    assign rd_issue_s = rd_start_s |
                        (((state_r == ST_RD_HDR) || (state_r == ST_RD_DATA)) &&
                         (iss_cnt_r <= {1'b0, len_s}) && (occ_s < 3'd2));

    // Next-state and per-cycle control decode
    always_comb begin
        state_s    = state_r;
        err_s      = 1'b0;
        wr_en_s    = 1'b0;
        cnt_inc_s  = 1'b0;
        accept_s   = 1'b0;
        hdr_push_s = 1'b0;
        hdr_last_s = 1'b0;
        rd_start_s = 1'b0;
        drain_rd_s = drain_to_rd_r;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s) begin
                    accept_s = 1'b1;
                    if (I_TDATA[HDR_RNW]) begin
                        if (I_TLAST) begin
                            hdr_push_s = 1'b1;
                            rd_start_s = 1'b1;
                            state_s    = ST_RD_HDR;
                        end else begin
                            err_s      = 1'b1;
                            drain_rd_s = 1'b1;
                            state_s    = ST_DRAIN;
                        end
                    end else begin
                        if (I_TLAST) begin
                            err_s      = 1'b1;
                            hdr_push_s = 1'b1;
                            hdr_last_s = 1'b1;
                            state_s    = ST_WR_ACK;
                        end else begin
                            state_s = ST_WR_DATA;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (in_fire_s) begin
                    wr_en_s   = 1'b1;
                    cnt_inc_s = 1'b1;
                    if (I_TLAST) begin
                        err_s      = (beat_cnt_r != len_s);
                        hdr_push_s = 1'b1;
                        hdr_last_s = 1'b1;
                        state_s    = ST_WR_ACK;
                    end else if (beat_cnt_r == len_s) begin
                        err_s      = 1'b1;
                        drain_rd_s = 1'b0;
                        state_s    = ST_DRAIN;
                    end else begin
                        state_s = ST_WR_DATA;
                    end
                end else begin
                    state_s = ST_WR_DATA;
                end
            end
            ST_DRAIN: begin
                if (in_fire_s && I_TLAST) begin
                    hdr_push_s = 1'b1;
                    if (drain_to_rd_r) begin
                        rd_start_s = 1'b1;
                        state_s    = ST_RD_HDR;
                    end else begin
                        hdr_last_s = 1'b1;
                        state_s    = ST_WR_ACK;
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_WR_ACK: begin
                if (pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR_ACK;
                end
            end
            ST_RD_HDR: begin
                if (pop_s) begin
                    state_s = ST_RD_DATA;
                end else begin
                    state_s = ST_RD_HDR;
                end
            end
            ST_RD_DATA: begin
                if (pop_s && O_TLAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_DATA;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM, counters and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            hdr_r         <= 64'd0;
            drain_to_rd_r <= 1'b0;
            beat_cnt_r    <= 8'd0;
            iss_cnt_r     <= 9'd0;
            pend_r        <= 1'b0;
            pend_last_r   <= 1'b0;
            ready_r       <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            drain_to_rd_r <= drain_rd_s;
            ready_r       <= (state_s == ST_IDLE) || (state_s == ST_WR_DATA) ||
                             (state_s == ST_DRAIN);
            busy_r        <= (state_s != ST_IDLE);
            err_r         <= err_s;
            pend_r        <= rd_issue_s;
            pend_last_r   <= rd_last_s;
            if (accept_s) begin
                hdr_r <= I_TDATA;
            end
            // Counters idle at zero, so a new transaction always starts at beat 0
            if (state_s == ST_IDLE) begin
                beat_cnt_r <= 8'd0;
                iss_cnt_r  <= 9'd0;
            end else begin
                if (cnt_inc_s) begin
                    beat_cnt_r <= beat_cnt_r + 8'd1;
                end
                if (rd_issue_s) begin
                    iss_cnt_r <= iss_cnt_r + 9'd1;
                end
            end
        end
    end

    // RAM: byte-lane writes and a registered read port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en_s && wr_strb_s[i]) begin
                mem_r[wr_word_s][8*i +: 8] <= I_TDATA[8*i +: 8];
            end
        end
        if (rd_issue_s) begin
            ram_q_r <= mem_r[rd_word_s];
        end
    end

    // Header pushes and RAM returns never coincide
    assign skid_push_s = hdr_push_s | pend_r;
    assign skid_in_s   = hdr_push_s ? {hdr_last_s, resp_hdr_s} : {pend_last_r, ram_q_r};

    mic_skid2 #(.W(65)) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (skid_push_s),
        .in_data   (skid_in_s),
        .out_valid (O_TVALID),
        .out_ready (O_TREADY),
        .out_data  (skid_out_s),
        .count     (skid_cnt_s)
    );

    assign O_TDATA   = skid_out_s[63:0];
    assign O_TLAST   = skid_out_s[64];
    assign I_TREADY  = ready_r;
    assign busy      = busy_r;
    assign err_pulse = err_r;

endmodule
